// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, registers the ALU control code,
// detects load-use hazards and inserts bubbles on flush/hazard, with a saturating bubble counter.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_pc_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic [RW-1:0] id_rd_i,
    input  logic          id_uses_rt_i,
    input  logic [1:0]    id_aluop_i,
    input  logic [5:0]    id_funct_i,
    input  logic          id_alusrc_i,
    input  logic          id_regdst_i,
    input  logic          id_memread_i,
    input  logic          id_memwrite_i,
    input  logic          id_regwrite_i,
    input  logic          id_memtoreg_i,
    output logic          hazard_o,
    output logic          ex_valid_o,
    output logic [DW-1:0] ex_pc_o,
    output logic [DW-1:0] ex_rs_data_o,
    output logic [DW-1:0] ex_rt_data_o,
    output logic [DW-1:0] ex_imm_o,
    output logic [RW-1:0] ex_rs_o,
    output logic [RW-1:0] ex_rt_o,
    output logic [RW-1:0] ex_rd_o,
    output logic [2:0]    ex_aluctrl_o,
    output logic          ex_alusrc_o,
    output logic          ex_regdst_o,
    output logic          ex_memread_o,
    output logic          ex_memwrite_o,
    output logic          ex_regwrite_o,
    output logic          ex_memtoreg_o,
    output logic [CW-1:0] bubble_cnt_o
);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOP = 3'b100,
        ALU_SUB = 3'b110,
        ALU_MUL = 3'b111
    } alu_ctrl_e;

    alu_ctrl_e     w_aluctrl;
    alu_ctrl_e     r_aluctrl;
    logic          w_hazard;
    logic          w_bubble;
    logic          w_load_ctrl;

    logic          r_valid;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_rd;
    logic          r_alusrc;
    logic          r_regdst;
    logic          r_memread;
    logic          r_memwrite;
    logic          r_regwrite;
    logic          r_memtoreg;
    logic [CW-1:0] r_cnt;

    always_comb begin
        w_aluctrl = ALU_NOP;
        case (id_aluop_i)
            2'b00: w_aluctrl = ALU_ADD;
            2'b01: w_aluctrl = ALU_SUB;
            2'b10: begin
                case (id_funct_i)
                    6'b100000: w_aluctrl = ALU_ADD;
                    6'b100010: w_aluctrl = ALU_SUB;
                    6'b100100: w_aluctrl = ALU_AND;
                    6'b100101: w_aluctrl = ALU_OR;
                    6'b011000: w_aluctrl = ALU_MUL;
                    default:   w_aluctrl = ALU_NOP;
                endcase
            end
            default: w_aluctrl = ALU_NOP;
        endcase
    end

    // Only rt=$0 is exempt; a load into $0 still never blocks a consumer of another register.
    always_comb begin
        w_hazard = !stall_i && r_valid && r_memread && (r_rt != '0) && id_valid_i &&
                   ((r_rt == id_rs_i) || ((r_rt == id_rt_i) && id_uses_rt_i));
    end

    assign w_bubble    = flush_i | w_hazard;
    assign w_load_ctrl = !w_bubble && id_valid_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluctrl  <= ALU_NOP;
            r_cnt      <= '0;
        end else if (!stall_i) begin
            // Data fields always follow ID; only control is squashed on a bubble.
            r_pc       <= id_pc_i;
            r_rs_data  <= id_rs_data_i;
            r_rt_data  <= id_rt_data_i;
            r_imm      <= id_imm_i;
            r_rs       <= id_rs_i;
            r_rt       <= id_rt_i;
            r_rd       <= id_rd_i;
            r_valid    <= w_load_ctrl;
            r_alusrc   <= w_load_ctrl & id_alusrc_i;
            r_regdst   <= w_load_ctrl & id_regdst_i;
            r_memread  <= w_load_ctrl & id_memread_i;
            r_memwrite <= w_load_ctrl & id_memwrite_i;
            r_regwrite <= w_load_ctrl & id_regwrite_i;
            r_memtoreg <= w_load_ctrl & id_memtoreg_i;
            r_aluctrl  <= w_load_ctrl ? w_aluctrl : ALU_NOP;
            if (w_bubble && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign hazard_o      = w_hazard;
    assign ex_valid_o    = r_valid;
    assign ex_pc_o       = r_pc;
    assign ex_rs_data_o  = r_rs_data;
    assign ex_rt_data_o  = r_rt_data;
    assign ex_imm_o      = r_imm;
    assign ex_rs_o       = r_rs;
    assign ex_rt_o       = r_rt;
    assign ex_rd_o       = r_rd;
    assign ex_aluctrl_o  = r_aluctrl;
    assign ex_alusrc_o   = r_alusrc;
    assign ex_regdst_o   = r_regdst;
    assign ex_memread_o  = r_memread;
    assign ex_memwrite_o = r_memwrite;
    assign ex_regwrite_o = r_regwrite;
    assign ex_memtoreg_o = r_memtoreg;
    assign bubble_cnt_o  = r_cnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that feeds the EX-stage ALU and the forwarding unit.
- Latches decoded operands and control from ID.
- Produces the registered 3-bit ALU control code, so the ALU sees a stable op at the start of EX.
- Contains load-use hazard detection, bubble insertion for branch flush and cache stall hold, plus a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width (register data, PC, immediate)
- RW, 5, register address width
- CW, 16, bubble counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- stall_i  in  1  downstream (data cache) stall; hold all state
- flush_i  in  1  branch taken in ID; squash the instruction entering EX
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  DW  PC+4 of ID instruction
- id_rs_data_i, id_rt_data_i  in  DW  register file read data
- id_imm_i  in  DW  sign-extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  RW  register addresses
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- id_aluop_i  in  2  main-decoder ALU op class
- id_funct_i  in  6  instruction funct field
- id_alusrc_i, id_regdst_i, id_memread_i, id_memwrite_i, id_regwrite_i, id_memtoreg_i  in  1 each  control bits
- hazard_o  out  1  load-use stall request to PC/IF-ID (combinational)
- ex_valid_o  out  1  EX holds a real instruction
- ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DW  registered operands
- ex_rs_o, ex_rt_o, ex_rd_o  out  RW  registered addresses
- ex_aluctrl_o  out  3  ALU control code
- ex_alusrc_o, ex_regdst_o, ex_memread_o, ex_memwrite_o, ex_regwrite_o, ex_memtoreg_o  out  1 each
- bubble_cnt_o  out  CW  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_i low, asynchronous): all ex_* outputs 0 except ex_aluctrl_o = 3'b100 (nop); bubble_cnt_o = 0.
- hazard_o is combinational and asserted when all of the following hold:
  - ex_valid_o & ex_memread_o
  - ex_rt_o != 0
  - id_valid_i
  - ex_rt_o == id_rs_i, or (ex_rt_o == id_rt_i & id_uses_rt_i)
- hazard_o is forced 0 while stall_i = 1.
- ALU control decode, combinational from ID, registered into ex_aluctrl_o:
  - aluop 00 -> 010 (add; lw/sw/addi)
  - aluop 01 -> 110 (sub; beq)
  - aluop 10 -> decode funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 011000 -> 111 (mul)
    - any other funct -> 100 (nop)
  - aluop 11 -> 100 (nop)
- Per rising edge, priority order:
  1. stall_i=1: hold every register including bubble_cnt_o. flush_i and hazard are ignored (ID is also frozen, so they re-evaluate next cycle).
  2. else flush_i=1 or hazard_o=1: load a bubble; bubble_cnt_o increments.
     - Bubble = ex_valid_o=0, all six control bits 0, ex_aluctrl_o=100.
     - Data/address fields may load ID values (don't-care but deterministic).
  3. else: load all ID fields. ex_valid_o = id_valid_i.
     - If id_valid_i=0, control bits are forced 0 and aluctrl=100; no count.
- bubble_cnt_o saturates at all-ones and never wraps.
- Latency: one cycle from ID inputs to ex_* outputs. No combinational path from id_* inputs to ex_* outputs.
- A register write to $0 is never blocked by this stage. Hazard compare excludes rt=0 only.
- Reset mid-stall or mid-hazard: the asynchronous clear wins immediately; hazard_o drops since ex_valid_o=0.

Test Plan:
- Reset: hold rst_i=0 with random inputs toggling -> every ex_* output 0, ex_aluctrl_o=100, bubble_cnt_o=0; release -> first edge loads ID.
- ALU decode sweep:
  - aluop=10 with funct 100000/100010/100100/100101/011000/000000 -> aluctrl 010/110/000/001/111/100.
  - aluop 00/01/11 -> 010/110/100.
- Load-use:
  - EX holds lw rt=8. ID add rs=8 -> hazard_o=1; next edge EX is a bubble and bubble_cnt_o 0->1.
  - Repeat with rt=0 -> hazard_o=0.
  - Repeat with ID rt=8 and uses_rt=0 -> hazard_o=0.
- Flush: flush_i=1 with ID sub valid -> next cycle ex_valid_o=0, ex_regwrite_o=0, ex_aluctrl_o=100; count increments.
- Stall priority: stall_i=1 for 3 cycles while flush_i=1 and a hazard condition exists -> ex_* and bubble_cnt_o unchanged, hazard_o=0; after release, one bubble is inserted.
- Saturation: preload via 2^CW+2 flushes (CW=4 bench override) -> bubble_cnt_o holds 15.
